// File: rtl/uart_cmd_ctrl.sv
// ASCII command sequencer: "S<a><hh>" writes a 16x8 register bank, "G<a>" replies "<hh>\n".
// Optional write acknowledge "K\n" enabled by defining UART_CMD_ACK_EN.
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 10416,
  parameter int unsigned CNT_W          = 14
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  input  logic [7:0] reg_rdata,
  output logic       cmd_busy,
  output logic       cmd_err
);

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_G  = 8'h47;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_DHI, W_DLO, WRITE, R_ADDR, READ, TX_HI, TX_LO, TX_NL, TX_WAIT
  } state_t;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] b);
    if (b <= 8'h39)      return 4'(b - 8'h30);
    else if (b >= 8'h61) return 4'(b - 8'h57);
    else                 return 4'(b - 8'h37);
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  state_t           r_state, w_state_nxt;
  state_t           r_ret, w_ret_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_reply, w_reply_nxt;
  logic             r_ack, w_ack_nxt;
  logic [7:0]       r_tx_data, w_tx_data_nxt;
  logic             r_tx_start, w_tx_start_nxt;
  logic [3:0]       r_reg_addr, w_addr_nxt;
  logic [7:0]       r_reg_wdata, w_wdata_nxt;
  logic             r_reg_wr, w_wr_nxt;
  logic             r_cmd_busy;
  logic             r_cmd_err, w_err_nxt;
  logic             w_cnt_run;
  logic             w_timeout;

  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign reg_wr    = r_reg_wr;
  assign cmd_busy  = r_cmd_busy;
  assign cmd_err   = r_cmd_err;

  // Inter-character timeout only runs while a frame is partially received
  assign w_cnt_run = (r_state == W_ADDR) || (r_state == W_DHI) ||
                     (r_state == W_DLO)  || (r_state == R_ADDR);
  assign w_timeout = w_cnt_run && !rx_valid && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK) begin
    if (RST || rx_valid || !w_cnt_run) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_ret       <= IDLE;
      r_reply     <= '0;
      r_ack       <= 1'b0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_wr    <= 1'b0;
      r_cmd_busy  <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret       <= w_ret_nxt;
      r_reply     <= w_reply_nxt;
      r_ack       <= w_ack_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_reg_addr  <= w_addr_nxt;
      r_reg_wdata <= w_wdata_nxt;
      r_reg_wr    <= w_wr_nxt;
      r_cmd_busy  <= (w_state_nxt != IDLE);
      r_cmd_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ret_nxt      = r_ret;
    w_reply_nxt    = r_reply;
    w_ack_nxt      = r_ack;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    w_addr_nxt     = r_reg_addr;
    w_wdata_nxt    = r_reg_wdata;
    w_wr_nxt       = 1'b0;
    w_err_nxt      = 1'b0;

    if (w_timeout) begin
      w_err_nxt   = 1'b1;
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CH_S)                          w_state_nxt = W_ADDR;
            else if (rx_data == CH_G)                     w_state_nxt = R_ADDR;
            else if (rx_data != CH_LF && rx_data != CH_CR) w_err_nxt  = 1'b1;
          end
        end
        W_ADDR, R_ADDR: begin
          if (rx_valid) begin
            if (is_hex(rx_data)) begin
              w_addr_nxt  = hex_val(rx_data);
              w_state_nxt = (r_state == W_ADDR) ? W_DHI : READ;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
        W_DHI: begin
          if (rx_valid) begin
            if (is_hex(rx_data)) begin
              w_wdata_nxt = {hex_val(rx_data), r_reg_wdata[3:0]};
              w_state_nxt = W_DLO;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
        W_DLO: begin
          if (rx_valid) begin
            if (is_hex(rx_data)) begin
              w_wdata_nxt = {r_reg_wdata[7:4], hex_val(rx_data)};
              w_wr_nxt    = 1'b1;
              w_state_nxt = WRITE;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
        WRITE: begin
`ifdef UART_CMD_ACK_EN
          w_ack_nxt   = 1'b1;
          w_state_nxt = TX_HI;
`else
          w_state_nxt = IDLE;
`endif
        end
        READ: begin
          w_err_nxt   = rx_valid;
          w_reply_nxt = reg_rdata;
          w_ack_nxt   = 1'b0;
          w_state_nxt = TX_HI;
        end
        TX_HI, TX_LO, TX_NL: begin
          w_err_nxt = rx_valid;
          if (!tx_busy) begin
            w_tx_start_nxt = 1'b1;
            w_state_nxt    = TX_WAIT;
            if (r_state == TX_HI) begin
              w_tx_data_nxt = r_ack ? CH_K : hex_chr(r_reply[7:4]);
              w_ret_nxt     = r_ack ? TX_NL : TX_LO;
            end else if (r_state == TX_LO) begin
              w_tx_data_nxt = hex_chr(r_reply[3:0]);
              w_ret_nxt     = TX_NL;
            end else begin
              w_tx_data_nxt = CH_LF;
              w_ret_nxt     = IDLE;
            end
          end
        end
        TX_WAIT: begin
          // tx_busy may lag tx_start by a cycle, so the start cycle itself is not trusted
          w_err_nxt = rx_valid;
          if (!r_tx_start && !tx_busy) w_state_nxt = r_ret;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus random frames vs a frame-level model.
module tb_uart_cmd_ctrl;

  localparam int TX_LEN = 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic [7:0] reg_rdata;
  logic       cmd_busy;
  logic       cmd_err;

  logic [7:0]  bank [16];
  logic [7:0]  exp_bank [16];
  logic        do_seed = 1'b1;
  logic [11:0] wr_q[$], exp_wr_q[$];
  logic [7:0]  tx_q[$], exp_tx_q[$];
  int          err_cnt = 0, exp_err = 0, n_viol = 0, busy_cnt = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  tx_hold = 8'h00;

  uart_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
    .reg_rdata(reg_rdata), .cmd_busy(cmd_busy), .cmd_err(cmd_err)
  );

  always #5 CLK = ~CLK;

  assign reg_rdata = bank[reg_addr];

  // Register bank, transmitter model and event monitors
  always @(negedge CLK) begin
    if (do_seed) for (int i = 0; i < 16; i++) bank[i] = exp_bank[i];
    if (reg_wr) begin
      wr_q.push_back({reg_addr, reg_wdata});
      bank[reg_addr] = reg_wdata;
    end
    if (cmd_err) err_cnt++;
    if (busy_cnt > 0 && tx_data != tx_hold) n_viol++;
    if (tx_start) begin
      if (tx_busy) n_viol++;
      tx_q.push_back(tx_data);
      tx_hold  = tx_data;
      busy_cnt = TX_LEN;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] n, input bit lower);
    string s;
    s = lower ? "0123456789abcdef" : "0123456789ABCDEF";
    return s[n];
  endfunction

  task automatic exp_write(input logic [3:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
    exp_bank[a] = d;
`ifdef UART_CMD_ACK_EN
    exp_tx_q.push_back(8'h4B);
    exp_tx_q.push_back(8'h0A);
`endif
  endtask

  task automatic exp_read(input logic [3:0] a);
    exp_tx_q.push_back(enc(exp_bank[a][7:4], 1'b0));
    exp_tx_q.push_back(enc(exp_bank[a][3:0], 1'b0));
    exp_tx_q.push_back(8'h0A);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((cmd_busy || tx_busy) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) chk({tag, ":idle_bound"}, 32'd1, 32'd0);
    repeat (4) @(negedge CLK);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, ":wr_count"}, 32'(wr_q.size()), 32'(exp_wr_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++)
      chk({tag, ":wr"}, 32'(wr_q[i]), 32'(exp_wr_q[i]));
    chk({tag, ":tx_count"}, 32'(tx_q.size()), 32'(exp_tx_q.size()));
    for (int i = 0; i < tx_q.size() && i < exp_tx_q.size(); i++)
      chk({tag, ":tx"}, 32'(tx_q[i]), 32'(exp_tx_q[i]));
    chk({tag, ":err_count"}, 32'(err_cnt), 32'(exp_err));
    wr_q.delete(); exp_wr_q.delete(); tx_q.delete(); exp_tx_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, ":tx_data"},   32'(tx_data),   32'd0);
    chk({tag, ":tx_start"},  32'(tx_start),  32'd0);
    chk({tag, ":reg_addr"},  32'(reg_addr),  32'd0);
    chk({tag, ":reg_wdata"}, 32'(reg_wdata), 32'd0);
    chk({tag, ":reg_wr"},    32'(reg_wr),    32'd0);
    chk({tag, ":cmd_busy"},  32'(cmd_busy),  32'd0);
    chk({tag, ":cmd_err"},   32'(cmd_err),   32'd0);
  endtask

  initial begin
    logic [7:0] fq[$];
    logic [3:0] a;
    logic [7:0] d;
    string      bad;
    int         kind, pos, gap;
    bad = "XZ#gz@";
    for (int i = 0; i < 16; i++) exp_bank[i] = 8'($urandom_range(0, 255));

    repeat (3) @(negedge CLK);
    check_zero_outputs("reset");
    do_seed = 1'b0;
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // Write with real character spacing and strobe timing
    send_str("S0F", 1042);
    chk("s0f7:busy_mid", 32'(cmd_busy), 32'd1);
    @(negedge CLK);
    rx_data = "7"; rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    chk("s0f7:wr_strobe", 32'(reg_wr), 32'd1);
    @(negedge CLK);
    chk("s0f7:wr_one_cycle", 32'(reg_wr), 32'd0);
    exp_write(4'h0, 8'hF7);
    wait_idle("s0f7");
    chk("s0f7:busy_after", 32'(cmd_busy), 32'd0);
    check_frame("s0f7");

    // Write then read back
    send_str("S014\n", 200);
    exp_write(4'h0, 8'h14);
    wait_idle("s014");
    send_str("G0\n", 200);
    exp_read(4'h0);
    wait_idle("g0");
    check_frame("s014_g0");

    // Bad hex aborts; trailing '7' rejected in IDLE; next frame works
    send_str("S0X7", 40);
    exp_err += 2;
    wait_idle("s0x7");
    send_str("S1a5", 40);
    exp_write(4'h1, 8'hA5);
    wait_idle("s1a5");
    check_frame("bad_hex");

    // Inter-character timeout
    send_str("S0", 0);
    repeat (10300) @(negedge CLK);
    chk("timeout:early", 32'(err_cnt), 32'(exp_err));
    chk("timeout:busy_before", 32'(cmd_busy), 32'd1);
    repeat (200) @(negedge CLK);
    exp_err++;
    chk("timeout:err", 32'(err_cnt), 32'(exp_err));
    chk("timeout:busy_after", 32'(cmd_busy), 32'd0);
    send_str("7", 20);
    exp_err++;
    wait_idle("timeout");
    check_frame("timeout");

    // Byte injected during a reply is dropped
    send_str("G3", 15);
    send_byte("S", 0);
    exp_read(4'h3);
    exp_err++;
    wait_idle("g3_inject");
    check_frame("g3_inject");

    // Reset mid-frame
    send_str("S2", 20);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_zero_outputs("rst_mid");
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    send_str("S2AB", 30);
    exp_write(4'h2, 8'hAB);
    wait_idle("s2ab");
    check_frame("s2ab");

    // Random frames against the frame-level model
    for (int f = 0; f < 40; f++) begin
      fq.delete();
      kind = $urandom_range(0, 3);
      a    = 4'($urandom_range(0, 15));
      d    = 8'($urandom_range(0, 255));
      gap  = $urandom_range(20, 60);
      case (kind)
        0: begin
          fq.push_back("S");
          fq.push_back(enc(a, 1'($urandom_range(0, 1))));
          fq.push_back(enc(d[7:4], 1'($urandom_range(0, 1))));
          fq.push_back(enc(d[3:0], 1'($urandom_range(0, 1))));
          exp_write(a, d);
        end
        1: begin
          fq.push_back("G");
          fq.push_back(enc(a, 1'($urandom_range(0, 1))));
          exp_read(a);
        end
        2: begin
          pos = $urandom_range(0, 3);
          if (pos == 0) begin
            fq.push_back("G");
          end else begin
            fq.push_back("S");
            if (pos > 1) fq.push_back(enc(a, 1'b0));
            if (pos > 2) fq.push_back(enc(d[7:4], 1'b1));
          end
          fq.push_back(bad[$urandom_range(0, 5)]);
          exp_err++;
        end
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            fq.push_back(bad[$urandom_range(0, 5)]);
            exp_err++;
          end else begin
            fq.push_back(($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D);
          end
        end
      endcase
      foreach (fq[i]) send_byte(fq[i], gap);
      wait_idle("rand");
      check_frame("rand");
    end

    chk("tx_handshake_violations", 32'(n_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART receiver/transmitter byte interfaces and an internal 16 x 8-bit register bank.
- Parses ASCII frames arriving on the 115200-baud serial link (12 MHz CLK): 'S' writes a register; 'G' reads one back.
- Issues register write strobes and schedules the reply bytes onto the shared UART transmitter.

Parameters:
- TIMEOUT_CYCLES, 10416: inter-character timeout in CLK cycles (about 10 character times at 115200 baud); a partial frame is aborted when this is reached.
- CNT_W, 14: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock, 12 MHz
- RST  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid while rx_valid is high
- rx_valid  in  1  one-cycle strobe per received byte
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls
- tx_start  out  1  one-cycle request to transmit tx_data
- tx_busy  in  1  transmitter busy
- reg_addr  out  4  register address
- reg_wdata  out  8  register write data
- reg_wr  out  1  one-cycle register write strobe
- reg_rdata  in  8  register read data; combinational from reg_addr
- cmd_busy  out  1  high whenever state is not IDLE
- cmd_err  out  1  one-cycle error pulse

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset: all outputs are 0 and state is IDLE. RST asserted mid-frame or mid-reply aborts immediately; a byte already handed to the transmitter completes on its own.
- Hex characters: '0'-'9', 'A'-'F' and 'a'-'f' decode to 0-15. Any other byte in a hex position is an error.
- States: IDLE, W_ADDR, W_DHI, W_DLO, WRITE, R_ADDR, READ, TX_HI, TX_LO, TX_NL, TX_WAIT.
- IDLE on rx_valid:
  - 'S' moves to W_ADDR.
  - 'G' moves to R_ADDR.
  - 0x0A and 0x0D are ignored silently.
  - Any other byte pulses cmd_err and stays in IDLE.
- Write path: W_ADDR captures reg_addr, W_DHI captures reg_wdata[7:4], W_DLO captures reg_wdata[3:0], then WRITE.
- WRITE: reg_wr is high for exactly one cycle, the cycle after the rx_valid of the last hex character. The state then returns to IDLE, or goes to the ACK sequence (see Optional Feature).
- No terminator is required. A trailing '\n' is consumed as an IDLE byte.
- Read path: R_ADDR captures reg_addr, then READ.
- READ: one cycle in which reg_rdata is sampled into an internal reply register. Then the reply is sent in order: upper-case hex of the high nibble, upper-case hex of the low nibble, 0x0A.
- TX handshake:
  - In a TX_* state, tx_start is pulsed for one cycle once tx_busy is 0, with tx_data set in the same cycle.
  - TX_WAIT ignores tx_busy for the first cycle after tx_start, then waits for tx_busy to be 0 before moving to the next TX_* state or to IDLE.
- Error and abort conditions (all pulse cmd_err for one cycle and return to IDLE with no reg_wr):
  - Non-hex byte in W_ADDR, W_DHI, W_DLO or R_ADDR; the byte is discarded.
  - Timeout: the counter clears on every rx_valid and counts in W_*/R_ADDR states only; reaching TIMEOUT_CYCLES aborts the frame.
  - rx_valid during READ, TX_* or TX_WAIT: the byte is dropped and the reply continues uninterrupted.
- Simultaneous events: rx_valid in the same cycle the timeout is reached means the byte wins and the counter clears.
- reg_addr and reg_wdata hold their last values between frames.

Optional Feature:
- Macro: UART_CMD_ACK_EN.
- Defined: after WRITE, the block transmits 'K' (0x4B) then 0x0A using the same TX handshake. rx_valid during the ACK is handled as during any reply.
- Undefined: writes produce no transmission and WRITE returns directly to IDLE.

Test Plan:
- Bytes "S0F7" at 1042-cycle spacing -> one reg_wr pulse with reg_addr=0x0, reg_wdata=0xF7; no cmd_err; cmd_busy low afterwards.
- "S014\n" then "G0\n" with the bank returning 0x14 -> tx bytes 0x31, 0x34, 0x0A in order; each tx_start is issued only while tx_busy=0.
- "S0X7" -> cmd_err pulse on the 'X' byte; no reg_wr; the following "S1a5" writes 0xA5 to address 1.
- "S0" followed by 10416 idle cycles -> cmd_err pulse at the timeout, return to IDLE; the later "7" is rejected in IDLE with cmd_err.
- "G3" then an 'S' byte injected during the reply -> reply completes unchanged; cmd_err pulses on the dropped 'S'.
- RST during W_DHI of "S2" -> all outputs 0; then "S2AB" writes 0xAB. With UART_CMD_ACK_EN defined, the write is followed by tx bytes 0x4B, 0x0A.
